// File: rtl/legv8_pkg.sv
// Shared LEGv8 mnemonic codes, opcode fields and encoder FSM states (also used by the control decoder).
// Latency: none (constants and types only).
// Backpressure: not applicable.
package legv8_pkg;

  typedef enum logic [3:0] {
    MN_B    = 4'd0,
    MN_BL   = 4'd1,
    MN_BLT  = 4'd2,
    MN_CBZ  = 4'd3,
    MN_ADDS = 4'd4,
    MN_SUBS = 4'd5,
    MN_BR   = 4'd6,
    MN_ADDI = 4'd7,
    MN_LDUR = 4'd8,
    MN_STUR = 4'd9
  } mnem_t;

  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;
  localparam logic [7:0]  OPC_BLT  = 8'b01010100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_BR   = 11'b11010110000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  localparam logic [4:0]  COND_LT  = 5'b01011;
  // ADDI X31,X31,#0
  localparam logic [31:0] NOP_WORD = 32'h910003FF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [3:0]  mnem;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [15:0] imm;
  } req_t;

  // True when a 16-bit signed value lies in [-256, 255].
  function automatic logic fits_simm9(input logic [15:0] v);
    return (v[15:8] == 8'h00) || (v[15:8] == 8'hFF);
  endfunction

endpackage

// File: rtl/legv8_branch_offset.sv
// Combinational pc/target to word-offset converter with signed-range and alignment flags.
// Latency: combinational, zero cycles.
// Backpressure: not applicable. ADDR_W must be at least 27.
module legv8_branch_offset #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  output logic [25:0]       off26,
  output logic              fits19,
  output logic              fits26,
  output logic              misaligned
);

  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] sh;

  // Difference is taken modulo 2^ADDR_W so wrapped programs still reach their targets.
  assign diff = target - pc;
  assign sh   = $unsigned($signed(diff) >>> 2);

  assign off26      = sh[25:0];
  assign fits19     = (&sh[ADDR_W-1:18]) || !(|sh[ADDR_W-1:18]);
  assign fits26     = (&sh[ADDR_W-1:25]) || !(|sh[ADDR_W-1:25]);
  assign misaligned = |target[1:0];

endmodule

// File: rtl/legv8_instr_encoder.sv
// Encodes symbolic LEGv8 requests into machine words and writes them sequentially to imem.
// Latency: request accepted at edge N drives wr_en from cycle N+2; one word per 3 cycles best case.
// Backpressure: in_ready low outside IDLE; WR holds wr_addr/wr_data until wr_ready.
// Build option ENCODER_NOP_FILL_EN: rejected requests write NOP_WORD instead of being dropped.
module legv8_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [15:0]       imm,
  input  logic [ADDR_W-1:0] target,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic              err_sticky,
  output logic [15:0]       count
);

  import legv8_pkg::*;

  enc_state_t        state_q, state_d;
  logic              rst_done_q;
  req_t              req_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       enc_word;
  logic              enc_err;
  logic [25:0]       off26;
  logic              fits19, fits26, misaligned;

  legv8_branch_offset #(.ADDR_W(ADDR_W)) u_branch_offset (
    .pc         (pc_q),
    .target     (tgt_q),
    .off26      (off26),
    .fits19     (fits19),
    .fits26     (fits26),
    .misaligned (misaligned)
  );

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (req_q.mnem)
      MN_B: begin
        enc_word = {OPC_B, off26};
        enc_err  = misaligned || !fits26;
      end
      MN_BL: begin
        enc_word = {OPC_BL, off26};
        enc_err  = misaligned || !fits26;
      end
      MN_BLT: begin
        enc_word = {OPC_BLT, off26[18:0], COND_LT};
        enc_err  = misaligned || !fits19;
      end
      MN_CBZ: begin
        enc_word = {OPC_CBZ, off26[18:0], req_q.rd};
        enc_err  = misaligned || !fits19;
      end
      MN_ADDS: enc_word = {OPC_ADDS, req_q.rm, 6'd0, req_q.rn, req_q.rd};
      MN_SUBS: enc_word = {OPC_SUBS, req_q.rm, 6'd0, req_q.rn, req_q.rd};
      MN_BR:   enc_word = {OPC_BR, 5'd0, 6'd0, req_q.rn, 5'd0};
      MN_ADDI: begin
        enc_word = {OPC_ADDI, req_q.imm[11:0], req_q.rn, req_q.rd};
        enc_err  = |req_q.imm[15:12];
      end
      MN_LDUR: begin
        enc_word = {OPC_LDUR, req_q.imm[8:0], 2'b00, req_q.rn, req_q.rd};
        enc_err  = !fits_simm9(req_q.imm);
      end
      MN_STUR: begin
        enc_word = {OPC_STUR, req_q.imm[8:0], 2'b00, req_q.rn, req_q.rd};
        enc_err  = !fits_simm9(req_q.imm);
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = rst_done_q;
        if (in_valid && rst_done_q) state_d = S_ENC;
      end
      S_ENC: begin
`ifdef ENCODER_NOP_FILL_EN
        state_d = S_WR;
`else
        state_d = enc_err ? S_IDLE : S_WR;
`endif
      end
      S_WR: begin
        wr_en = 1'b1;
        if (wr_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_done_q <= 1'b0;
      req_q      <= '0;
      tgt_q      <= '0;
      pc_q       <= BASE_ADDR;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      count      <= '0;
    end else begin
      rst_done_q <= 1'b1;
      err        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (restart) begin
            pc_q       <= BASE_ADDR;
            count      <= '0;
            err_sticky <= 1'b0;
          end
          if (in_valid && in_ready) begin
            req_q <= '{mnem: mnem, rd: rd, rn: rn, rm: rm, imm: imm};
            tgt_q <= target;
          end
        end
        S_ENC: begin
          if (enc_err) begin
            err        <= 1'b1;
            err_sticky <= 1'b1;
`ifdef ENCODER_NOP_FILL_EN
            wr_addr    <= pc_q;
            wr_data    <= NOP_WORD;
`endif
          end else begin
            wr_addr <= pc_q;
            wr_data <= enc_word;
          end
        end
        S_WR: begin
          if (wr_ready) begin
            pc_q <= pc_q + ADDR_W'(4);
            if (count != 16'hFFFF) count <= count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed table-driven bench for legv8_instr_encoder plus backpressure, restart and reset sequences.
module tb_legv8_instr_encoder;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, wr_ready;
  logic [3:0]  mnem;
  logic [4:0]  rd, rn, rm;
  logic [15:0] imm;
  logic [31:0] target;
  logic        in_ready, wr_en, err, err_sticky;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] count;

  always #5 clk = ~clk;

  legv8_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .target(target),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .err_sticky(err_sticky), .count(count)
  );

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rd, rn, rm;
    logic [15:0] imm;
    int          rel;   // target relative to the current model pc
    logic        bad;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  int passed = 0;
  int total  = 0;
  logic [31:0] mpc = 32'h0;
  int mcount = 0;

  function automatic vec_t mk(input logic [3:0] m, input logic [4:0] d, input logic [4:0] n,
                              input logic [4:0] r, input logic [15:0] i, input int rl,
                              input logic b, input logic [31:0] w);
    vec_t v;
    v.mnem = m; v.rd = d; v.rn = n; v.rm = r; v.imm = i; v.rel = rl; v.bad = b; v.word = w;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Presents a request and returns at the negedge after acceptance (DUT in ENC).
  task automatic send(input vec_t v);
    int n;
    @(negedge clk);
    mnem = v.mnem; rd = v.rd; rn = v.rn; rm = v.rm; imm = v.imm;
    target = mpc + 32'(v.rel);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    logic wrote;
    send(v);
    chk({nm, "_enc_wr_en"}, {31'b0, wr_en}, 32'd0);
    @(negedge clk);
    wrote = !v.bad;
    if (v.bad) begin
      chk({nm, "_err"}, {31'b0, err}, 32'd1);
      chk({nm, "_sticky"}, {31'b0, err_sticky}, 32'd1);
`ifdef ENCODER_NOP_FILL_EN
      chk({nm, "_nop_data"}, wr_data, NOP_WORD);
      chk({nm, "_nop_addr"}, wr_addr, mpc);
      wrote = 1'b1;
`else
      chk({nm, "_no_wr"}, {31'b0, wr_en}, 32'd0);
`endif
    end else begin
      chk({nm, "_wr_en"}, {31'b0, wr_en}, 32'd1);
      chk({nm, "_addr"}, wr_addr, mpc);
      chk({nm, "_data"}, wr_data, v.word);
      chk({nm, "_err"}, {31'b0, err}, 32'd0);
    end
    @(negedge clk);
    if (wrote) begin
      mpc += 32'd4;
      mcount++;
    end
    chk({nm, "_err_pulse_end"}, {31'b0, err}, 32'd0);
    chk({nm, "_count"}, {16'b0, count}, 32'(mcount));
    chk({nm, "_idle_rdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = mk(MN_ADDI, 5'd1, 5'd31, 5'd0, 16'd5,     0,          1'b0, 32'h910017E1);
    vecs[1]  = mk(MN_ADDS, 5'd3, 5'd1,  5'd2, 16'd0,     0,          1'b0, 32'hAB020023);
    vecs[2]  = mk(MN_B,    5'd0, 5'd0,  5'd0, 16'd0,     -8,         1'b0, 32'h17FFFFFE);
    vecs[3]  = mk(MN_CBZ,  5'd3, 5'd0,  5'd0, 16'd0,     16,         1'b0, 32'hB4000083);
    vecs[4]  = mk(MN_LDUR, 5'd2, 5'd5,  5'd0, 16'hFFF8,  0,          1'b0, 32'hF85F80A2);
    vecs[5]  = mk(MN_LDUR, 5'd2, 5'd5,  5'd0, 16'd300,   0,          1'b1, 32'h0);
    vecs[6]  = mk(MN_STUR, 5'd7, 5'd8,  5'd0, 16'd255,   0,          1'b0, 32'hF80FF107);
    vecs[7]  = mk(MN_ADDI, 5'd1, 5'd1,  5'd0, 16'd4096,  0,          1'b1, 32'h0);
    vecs[8]  = mk(MN_BR,   5'd0, 5'd30, 5'd0, 16'd0,     0,          1'b0, 32'hD60003C0);
    vecs[9]  = mk(MN_BLT,  5'd0, 5'd0,  5'd0, 16'd0,     2,          1'b1, 32'h0);
    vecs[10] = mk(4'd15,   5'd0, 5'd0,  5'd0, 16'd0,     0,          1'b1, 32'h0);
    vecs[11] = mk(MN_BL,   5'd0, 5'd0,  5'd0, 16'd0,     32'h100,    1'b0, 32'h94000040);
    vecs[12] = mk(MN_BLT,  5'd0, 5'd0,  5'd0, 16'd0,     0,          1'b0, 32'h5400000B);
    vecs[13] = mk(MN_SUBS, 5'd0, 5'd1,  5'd2, 16'd0,     0,          1'b0, 32'hEB020020);
    vecs[14] = mk(MN_CBZ,  5'd1, 5'd0,  5'd0, 16'd0,     32'h400000, 1'b1, 32'h0);
    vecs[15] = mk(MN_B,    5'd0, 5'd0,  5'd0, 16'd0,     32'h7FFFFFC, 1'b0, 32'h15FFFFFF);
    vecs[16] = mk(MN_B,    5'd0, 5'd0,  5'd0, 16'd0,     32'h8000000, 1'b1, 32'h0);
    vecs[17] = mk(MN_LDUR, 5'd2, 5'd1,  5'd0, 16'hFF00,  0,          1'b0, 32'hF8500022);
    vecs[18] = mk(MN_CBZ,  5'd0, 5'd0,  5'd0, 16'd0,     -32'sh100000, 1'b0, 32'hB4800000);
    vecs[19] = mk(MN_ADDI, 5'd1, 5'd1,  5'd0, 16'hFFFF,  0,          1'b1, 32'h0);
    vecs[20] = mk(4'd10,   5'd0, 5'd0,  5'd0, 16'd0,     0,          1'b1, 32'h0);

    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    mnem = '0; rd = '0; rn = '0; rm = '0; imm = '0; target = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_err", {30'b0, err, err_sticky}, 32'd0);
    chk("rst_count", {16'b0, count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Backpressure: wr_ready low for three WR cycles.
    wr_ready = 1'b0;
    v = mk(MN_ADDI, 5'd4, 5'd4, 5'd0, 16'd1, 0, 1'b0, 32'h91000484);
    send(v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_wr_en", k), {31'b0, wr_en}, 32'd1);
      chk($sformatf("bp%0d_addr", k), wr_addr, mpc);
      chk($sformatf("bp%0d_data", k), wr_data, 32'h91000484);
      chk($sformatf("bp%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    mpc += 32'd4; mcount++;
    chk("bp_done_wr_en", {31'b0, wr_en}, 32'd0);
    chk("bp_done_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_done_count", {16'b0, count}, 32'(mcount));

    // Restart outside IDLE must be ignored.
    wr_ready = 1'b0;
    send(v);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_busy_addr", wr_addr, mpc);
    wr_ready = 1'b1;
    @(negedge clk);
    mpc += 32'd4; mcount++;
    chk("rs_busy_count", {16'b0, count}, 32'(mcount));
    chk("rs_busy_sticky", {31'b0, err_sticky}, 32'd1);
    run_vec("rs_busy_next", v);

    // Restart in IDLE clears pc, count and err_sticky.
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    mpc = 32'h0; mcount = 0;
    chk("rs_idle_sticky", {31'b0, err_sticky}, 32'd0);
    chk("rs_idle_count", {16'b0, count}, 32'd0);
    run_vec("rs_idle_next", vecs[0]);

    // Reset asserted while in WR drops wr_en without a clock edge.
    wr_ready = 1'b0;
    send(v);
    @(negedge clk);
    chk("rwr_pre_wr_en", {31'b0, wr_en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rwr_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rwr_count", {16'b0, count}, 32'd0);
    chk("rwr_addr", wr_addr, 32'h0);
    wr_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    mpc = 32'h0; mcount = 0;
    @(negedge clk);
    run_vec("rwr_next", vecs[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/legv8_instr_encoder.md
Name: legv8_instr_encoder

Overview:
- Encodes symbolic LEGv8 instruction requests (mnemonic, register fields, immediate or branch target) into 32-bit machine words.
- Writes the words sequentially into instruction memory through a valid/ready write port.
- It is the program-loader counterpart to the CPU's control decoder. Every word it emits must decode to the requested operation.
- Supported mnemonics: B, BL, B.LT, CBZ, ADDS, SUBS, BR, ADDI, LDUR, STUR.

Parameters:
- ADDR_W, 32: instruction-memory byte-address width.
- BASE_ADDR, 0: first write address after reset or restart; must be 4-byte aligned.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- restart  in  1  sync pulse; pc returns to BASE_ADDR and count clears; ignored unless in IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- mnem  in  4  mnemonic code (legv8_pkg::mnem_t).
- rd  in  5  Rd/Rt field.
- rn  in  5  Rn field.
- rm  in  5  Rm field.
- imm  in  16  signed immediate: ADDI uses imm[11:0] unsigned; LDUR/STUR use a signed 9-bit range.
- target  in  ADDR_W  branch target byte address (B, BL, B.LT, CBZ).
- wr_en  out  1  imem write valid.
- wr_ready  in  1  imem accepts write.
- wr_addr  out  ADDR_W  byte address of the word.
- wr_data  out  32  encoded word.
- err  out  1  one-cycle pulse: request rejected.
- err_sticky  out  1  set on any err; cleared by restart.
- count  out  16  words written since reset/restart.

Behaviour:
- Reset values:
  - in_ready=0 during reset, 1 the first cycle after reset.
  - wr_en=0, wr_addr=BASE_ADDR, wr_data=0.
  - err=0, err_sticky=0, count=0; internal pc=BASE_ADDR; state=IDLE.
- FSM states: IDLE, ENC, WR.
  - IDLE: in_ready=1. On in_valid&in_ready, capture all request fields and go to ENC.
  - ENC (1 cycle): form the word, run range checks, compute offset=(target-pc)>>>2 (signed).
    - Check passes: load wr_data/wr_addr=pc and go to WR.
    - Check fails: pulse err, set err_sticky, return to IDLE. Nothing is written and pc is unchanged.
  - WR: wr_en=1. wr_data and wr_addr are held stable until wr_ready. On wr_en&wr_ready: pc+=4, count+=1, go to IDLE.
- Latency: request accepted at edge N gives wr_en high from cycle N+2. Best-case throughput is one word per 3 cycles.
- Encodings (bit ranges):
  - B: 000101 | imm26.
  - BL: 100101 | imm26.
  - B.LT: 01010100 | imm19[23:5] | cond 01011.
  - CBZ: 10110100 | imm19 | Rt.
  - ADDS: 10101011000 | Rm | shamt=0 | Rn | Rd.
  - SUBS: 11101011000 | Rm | shamt=0 | Rn | Rd.
  - BR: 11010110000 | 00000 | 000000 | Rn | 00000.
  - ADDI: 1001000100 | imm12 | Rn | Rd.
  - LDUR: 11111000010 | imm9 | 00 | Rn | Rt.
  - STUR: 11111000000 | imm9 | 00 | Rn | Rt.
- Range errors:
  - target[1:0]!=0.
  - B/BL offset outside signed 26 bits.
  - B.LT/CBZ offset outside signed 19 bits.
  - LDUR/STUR imm outside [-256, 255].
  - ADDI imm outside [0, 4095].
  - Undefined mnem code.
- Boundaries:
  - pc wraps modulo 2^ADDR_W with no error.
  - count saturates at 0xFFFF.
  - Offset 0 (branch to self) is legal.
  - restart outside IDLE is ignored.
  - Reset asserted mid-WR drops wr_en immediately (asynchronously); the pending word is lost.

Optional Feature:
- ENCODER_NOP_FILL_EN defined: a range error still pulses err and sets err_sticky. The FSM then goes to WR with wr_data=0x910003FF (ADDI X31,X31,#0), and pc/count advance, so the program layout is preserved.
- Undefined: the rejected request is dropped with no write.

Decomposition:
- legv8_pkg holds:
  - the mnem_t enum.
  - opcode constants OPC_B, OPC_BL, OPC_BLT, OPC_CBZ, OPC_ADDS, OPC_SUBS, OPC_BR, OPC_ADDI, OPC_LDUR, OPC_STUR.
  - COND_LT=5'b01011 and NOP_WORD.
- The control decoder shares the same opcode constants.
- One sub-module, legv8_branch_offset: a combinational pc/target to offset converter with fits19/fits26/misaligned flags.

Test Plan:
- ADDI X1,X31,#5 at pc 0 -> wr_en at cycle 2, wr_addr=0x0, wr_data=0x910017E1, count=1.
- B at pc 0x8, target 0x0 -> wr_data=0x17FFFFFE; CBZ X3 at pc 0xC, target 0x1C -> 0xB4000083.
- B.LT at pc 0x4, target 0x4 -> wr_data=0x5400000B; LDUR X2,[X5,#-8] -> 0xF85F80A2.
- LDUR imm=300 -> err pulse 1 cycle, err_sticky=1, no wr_en, pc and count unchanged; with ENCODER_NOP_FILL_EN -> 0x910003FF written, pc advances.
- wr_ready held low 3 cycles during WR -> wr_en/wr_addr/wr_data stable, in_ready=0; accepted on 4th cycle, then in_ready=1.
- reset asserted in WR -> wr_en=0 same cycle, pc=BASE_ADDR, count=0; restart pulse in IDLE -> pc=BASE_ADDR, err_sticky cleared.
